// File: rtl/psg_register_bank_if.sv
// CPU-side bus of the PSG register bank: data byte, write strobe, per-chip selects and the ready wait line.
// The stereoSel signal exists only when PSG_STEREO_EN is defined.
interface psg_register_bank_if #(
    parameter int CHIPS = 1
);
    logic [7:0]       d;
    logic             nWE;
    logic [CHIPS-1:0] nCE;
`ifdef PSG_STEREO_EN
    logic             stereoSel;
`endif
    logic             ready;

`ifdef PSG_STEREO_EN
    modport master (output d, output nWE, output nCE, output stereoSel, input ready);
    modport slave  (input d, input nWE, input nCE, input stereoSel, output ready);
`else
    modport master (output d, output nWE, output nCE, input ready);
    modport slave  (input d, input nWE, input nCE, output ready);
`endif
endinterface

// File: rtl/psg_register_bank.sv
// Latch/data byte register bank for CHIPS SN76489-compatible PSG cores, with a WAIT_CYCLES ready wait-state.
// Optional Game Gear stereo register per chip is enabled by defining PSG_STEREO_EN.
module psg_register_bank #(
    parameter int CHIPS       = 1,
    parameter int WAIT_CYCLES = 32
) (
    input  logic                clock,
    input  logic                nReset,
    psg_register_bank_if.slave  bus,
    output logic [CHIPS*30-1:0] freq,
    output logic [CHIPS*16-1:0] att,
    output logic [CHIPS-1:0]    noiseFeedback,
    output logic [CHIPS*2-1:0]  noiseFeed,
    output logic [CHIPS-1:0]    noiseReset
`ifdef PSG_STEREO_EN
    ,
    output logic [CHIPS*8-1:0]  stereo
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(WAIT_CYCLES - 1);

    logic [1:0]       state_r;
    logic [7:0]       cnt_r;
    logic [7:0]       data_r;
    logic [CHIPS-1:0] mask_r;
    logic             ready_r;
    logic             strobe_s;
    logic             commit_s;
    logic             sel_s;

    assign strobe_s = !bus.nWE && !(&bus.nCE);
    assign commit_s = (state_r == ST_WAIT) && (cnt_r == LAST_CNT);
    assign bus.ready = ready_r;

`ifdef PSG_STEREO_EN
    logic sel_r;
    assign sel_s = sel_r;

    // Capture of the stereo-select qualifier alongside the strobe.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            sel_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && strobe_s) begin
            sel_r <= bus.stereoSel;
        end else begin
            sel_r <= sel_r;
        end
    end
`else
    assign sel_s = 1'b0;
`endif

    // Write-cycle sequencer: capture strobe, hold ready low for WAIT_CYCLES, wait for strobe release.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            data_r  <= 8'd0;
            mask_r  <= {CHIPS{1'b0}};
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (strobe_s) begin
                        data_r  <= bus.d;
                        mask_r  <= ~bus.nCE;
                        cnt_r   <= 8'd0;
                        state_r <= ST_WAIT;
                        ready_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (commit_s) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    // A strobe still held after the commit must not start a second write.
                    if ((&bus.nCE) && bus.nWE) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < CHIPS; k++) begin : g_chip
        logic [2:0] reg_r;
        logic [9:0] freq_r [3];
        logic [3:0] att_r  [4];
        logic       fb_r;
        logic [1:0] feed_r;
        logic       nrst_r;
        logic [2:0] eff_s;
        logic       latch_s;
        logic       wr_s;

        // A data byte reuses the chip's own latched register; a latch byte names it directly.
        assign latch_s = data_r[7];
        assign eff_s   = latch_s ? data_r[6:4] : reg_r;
        assign wr_s    = commit_s && mask_r[k] && !sel_s;

        // PSG register file of chip k, updated on the commit edge.
        always_ff @(posedge clock) begin
            if (!nReset) begin
                reg_r  <= 3'd0;
                fb_r   <= 1'b0;
                feed_r <= 2'd0;
                nrst_r <= 1'b0;
                for (int c = 0; c < 3; c++) freq_r[c] <= 10'd0;
                for (int c = 0; c < 4; c++) att_r[c]  <= 4'hF;
            end else begin
                nrst_r <= 1'b0;
                if (wr_s) begin
                    if (latch_s) reg_r <= data_r[6:4];
                    case (eff_s)
                        3'd0: if (latch_s) freq_r[0][3:0] <= data_r[3:0]; else freq_r[0][9:4] <= data_r[5:0];
                        3'd2: if (latch_s) freq_r[1][3:0] <= data_r[3:0]; else freq_r[1][9:4] <= data_r[5:0];
                        3'd4: if (latch_s) freq_r[2][3:0] <= data_r[3:0]; else freq_r[2][9:4] <= data_r[5:0];
                        3'd6: begin
                            fb_r   <= data_r[2];
                            feed_r <= data_r[1:0];
                            nrst_r <= 1'b1;
                        end
                        // Odd registers are attenuations, channel (r-1)/2 = r[2:1].
                        default: att_r[eff_s[2:1]] <= data_r[3:0];
                    endcase
                end
            end
        end

`ifdef PSG_STEREO_EN
        logic [7:0] stereo_r;

        // Game Gear pan register of chip k.
        always_ff @(posedge clock) begin
            if (!nReset) begin
                stereo_r <= 8'hFF;
            end else if (commit_s && mask_r[k] && sel_s) begin
                stereo_r <= data_r;
            end else begin
                stereo_r <= stereo_r;
            end
        end
        assign stereo[k*8 +: 8] = stereo_r;
`endif

        for (genvar c = 0; c < 3; c++) begin : g_freq
            assign freq[(k*3+c)*10 +: 10] = freq_r[c];
        end
        for (genvar c = 0; c < 4; c++) begin : g_att
            assign att[(k*4+c)*4 +: 4] = att_r[c];
        end
        assign noiseFeedback[k]    = fb_r;
        assign noiseFeed[k*2 +: 2] = feed_r;
        assign noiseReset[k]       = nrst_r;
    end

endmodule

// File: tb/tb_psg_register_bank.sv
// Directed bench for psg_register_bank with two chips and a 32-cycle wait-state.
// Stereo checks are included when PSG_STEREO_EN is defined.
module tb_psg_register_bank;

    localparam int CHIPS = 2;
    localparam int WAITC = 32;

    logic        clock;
    logic        nReset;
    logic [59:0] freq;
    logic [31:0] att;
    logic [1:0]  noiseFeedback;
    logic [3:0]  noiseFeed;
    logic [1:0]  noiseReset;
`ifdef PSG_STEREO_EN
    logic [15:0] stereo;
`endif

    int total = 0;
    int bad   = 0;

    psg_register_bank_if #(.CHIPS(CHIPS)) bus_if ();

    psg_register_bank #(.CHIPS(CHIPS), .WAIT_CYCLES(WAITC)) dut (
        .clock         (clock),
        .nReset        (nReset),
        .bus           (bus_if),
        .freq          (freq),
        .att           (att),
        .noiseFeedback (noiseFeedback),
        .noiseFeed     (noiseFeed),
        .noiseReset    (noiseReset)
`ifdef PSG_STEREO_EN
        ,
        .stereo        (stereo)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full write: strobe for one edge, count ready-low cycles, release on the first ready-high negedge.
    task automatic do_write(input logic [7:0] data, input logic [1:0] ce, input logic sel, output int low);
        @(negedge clock);
        bus_if.d   = data;
        bus_if.nWE = 1'b0;
        bus_if.nCE = ce;
`ifdef PSG_STEREO_EN
        bus_if.stereoSel = sel;
`endif
        @(posedge clock);
        low = 0;
        @(negedge clock);
        while (bus_if.ready === 1'b0 && low < 200) begin
            low++;
            @(negedge clock);
        end
        bus_if.nWE = 1'b1;
        bus_if.nCE = 2'b11;
`ifdef PSG_STEREO_EN
        bus_if.stereoSel = 1'b0;
`endif
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus_if.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus_if.ready); end
        total++; if (freq !== 60'd0) begin bad++; $display("FAIL reset_freq got %h want 0", freq); end
        total++; if (att !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_att got %h want ffffffff", att); end
        total++; if ({noiseFeedback, noiseFeed, noiseReset} !== 8'd0) begin bad++; $display("FAIL reset_noise got %b want 0", {noiseFeedback, noiseFeed, noiseReset}); end
`ifdef PSG_STEREO_EN
        total++; if (stereo !== 16'hFFFF) begin bad++; $display("FAIL reset_stereo got %h want ffff", stereo); end
`endif
        nReset = 1'b1;
    endtask

    task automatic test_tone();
        int low;
        do_write(8'h8A, 2'b10, 1'b0, low);
        total++; if (low !== 32) begin bad++; $display("FAIL tone_latch_wait got %0d want 32", low); end
        total++; if (freq[9:0] !== 10'h00A) begin bad++; $display("FAIL tone_latch_freq got %h want 00a", freq[9:0]); end
        do_write(8'h3F, 2'b10, 1'b0, low);
        total++; if (low !== 32) begin bad++; $display("FAIL tone_data_wait got %0d want 32", low); end
        total++; if (freq[9:0] !== 10'h3FA) begin bad++; $display("FAIL tone_data_freq got %h want 3fa", freq[9:0]); end
        total++; if (freq[59:30] !== 30'd0) begin bad++; $display("FAIL tone_chip1_untouched got %h want 0", freq[59:30]); end
    endtask

    task automatic test_att();
        int low;
        do_write(8'h9F, 2'b10, 1'b0, low);
        total++; if (att[3:0] !== 4'hF) begin bad++; $display("FAIL att_latch got %h want f", att[3:0]); end
        do_write(8'h05, 2'b10, 1'b0, low);
        total++; if (att[3:0] !== 4'h5) begin bad++; $display("FAIL att_data got %h want 5", att[3:0]); end
        total++; if (freq[9:0] !== 10'h3FA) begin bad++; $display("FAIL att_freq_kept got %h want 3fa", freq[9:0]); end
    endtask

    task automatic test_noise();
        int low;
        do_write(8'hE5, 2'b10, 1'b0, low);
        total++; if ({noiseFeedback[0], noiseFeed[1:0]} !== 3'b101) begin bad++; $display("FAIL noise_latch got %b want 101", {noiseFeedback[0], noiseFeed[1:0]}); end
        total++; if (noiseReset !== 2'b01) begin bad++; $display("FAIL noise_pulse1_hi got %b want 01", noiseReset); end
        @(negedge clock);
        total++; if (noiseReset !== 2'b00) begin bad++; $display("FAIL noise_pulse1_lo got %b want 00", noiseReset); end
        do_write(8'h02, 2'b10, 1'b0, low);
        total++; if ({noiseFeedback[0], noiseFeed[1:0]} !== 3'b010) begin bad++; $display("FAIL noise_data got %b want 010", {noiseFeedback[0], noiseFeed[1:0]}); end
        total++; if (noiseReset !== 2'b01) begin bad++; $display("FAIL noise_pulse2_hi got %b want 01", noiseReset); end
        @(negedge clock);
        total++; if (noiseReset !== 2'b00) begin bad++; $display("FAIL noise_pulse2_lo got %b want 00", noiseReset); end
    endtask

    task automatic test_broadcast();
        int low;
        do_write(8'hD0, 2'b00, 1'b0, low);
        total++; if (low !== 32) begin bad++; $display("FAIL bcast_wait got %0d want 32", low); end
        total++; if ({att[27:24], att[11:8]} !== 8'h00) begin bad++; $display("FAIL bcast_att got %h want 00", {att[27:24], att[11:8]}); end
        do_write(8'h07, 2'b10, 1'b0, low);
        total++; if ({att[27:24], att[11:8]} !== 8'h07) begin bad++; $display("FAIL bcast_data_chip0 got %h want 07", {att[27:24], att[11:8]}); end
        total++; if (att[19:16] !== 4'hF) begin bad++; $display("FAIL bcast_chip1_ch0 got %h want f", att[19:16]); end
    endtask

    task automatic test_reset_mid_write();
        int low = 0;
        @(negedge clock);
        bus_if.d = 8'h85; bus_if.nWE = 1'b0; bus_if.nCE = 2'b00;
        @(posedge clock);
        repeat (10) begin
            @(negedge clock);
            if (bus_if.ready === 1'b0) low++;
        end
        total++; if (low !== 10) begin bad++; $display("FAIL mid_ready_low got %0d want 10", low); end
        nReset = 1'b0;
        @(negedge clock);
        total++; if (bus_if.ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got %b want 1", bus_if.ready); end
        total++; if (freq !== 60'd0 || att !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_reset_regs got %h/%h want 0/ffffffff", freq, att); end
        nReset = 1'b1;
        bus_if.nWE = 1'b1; bus_if.nCE = 2'b11;
        repeat (40) @(negedge clock);
        total++; if (att !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_no_late_commit got %h want ffffffff", att); end
    endtask

    task automatic test_hold_after_commit();
        int low = 0;
        @(negedge clock);
        bus_if.d = 8'h8C; bus_if.nWE = 1'b0; bus_if.nCE = 2'b10;
        @(posedge clock);
        repeat (5) @(negedge clock);
        bus_if.d = 8'h81;
        repeat (100) begin
            @(negedge clock);
            if (bus_if.ready === 1'b0) low++;
        end
        total++; if (low !== 27) begin bad++; $display("FAIL hold_ready_low got %0d want 27", low); end
        total++; if (freq[9:0] !== 10'h00C) begin bad++; $display("FAIL hold_single_commit got %h want 00c", freq[9:0]); end
        total++; if (att[3:0] !== 4'hF) begin bad++; $display("FAIL hold_no_second got %h want f", att[3:0]); end
        bus_if.nWE = 1'b1; bus_if.nCE = 2'b11;
    endtask

`ifdef PSG_STEREO_EN
    task automatic test_stereo();
        int low;
        do_write(8'h5A, 2'b10, 1'b1, low);
        total++; if (stereo !== 16'hFF5A) begin bad++; $display("FAIL stereo_write got %h want ff5a", stereo); end
        total++; if (freq[9:0] !== 10'h00C) begin bad++; $display("FAIL stereo_freq_kept got %h want 00c", freq[9:0]); end
        do_write(8'h21, 2'b10, 1'b0, low);
        total++; if (freq[9:0] !== 10'h21C) begin bad++; $display("FAIL stereo_r_kept got %h want 21c", freq[9:0]); end
    endtask
`endif

    initial begin
        bus_if.d = 8'h00; bus_if.nWE = 1'b1; bus_if.nCE = 2'b11;
`ifdef PSG_STEREO_EN
        bus_if.stereoSel = 1'b0;
`endif
        nReset = 1'b0;
        test_reset();
        test_tone();
        test_att();
        test_noise();
        test_broadcast();
        test_reset_mid_write();
        test_hold_after_commit();
`ifdef PSG_STEREO_EN
        test_stereo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psg_register_bank.md
# psg_register_bank

Parametrised CPU-side register bank for one or more SN76489-compatible PSG cores. It decodes the latch/data byte protocol, including partial tone updates and data-byte reuse of the latched register. It inserts a configurable wait-state on the CPU `ready` line, supports broadcast writes to several chips at once, and drives the tone, attenuation and noise controls consumed by the PSG tone/noise generators.

## Interface
Parameters:
- `CHIPS`, 1: number of PSG register sets, legal 1..4.
- `WAIT_CYCLES`, 32: clock cycles `ready` is held low per write, legal 1..255.

Ports:
- `clock` in 1: system clock. All logic is on the rising edge.
- `nReset` in 1: reset, synchronous, active-low.
- `d` in 8: CPU data bus.
- `nWE` in 1: write strobe, active-low.
- `nCE` in CHIPS: per-chip select, active-low. Several bits low at once means a broadcast write.
- `stereoSel` in 1: only with `PSG_STEREO_EN`. When high during a strobe, the write targets the stereo register.
- `ready` out 1: CPU wait line. Low means insert wait states.
- `freq` out CHIPS*30: 10-bit tone periods. Chip k, tone channel c is at bits [(k*3+c)*10 +: 10].
- `att` out CHIPS*16: 4-bit attenuations. Chip k, channel c is at bits [(k*4+c)*4 +: 4], with c=3 for noise.
- `noiseFeedback` out CHIPS: 1 selects white noise, 0 selects periodic.
- `noiseFeed` out CHIPS*2: noise shift-rate select.
- `noiseReset` out CHIPS: one-cycle pulse telling the generator to reload its LFSR.
- `stereo` out CHIPS*8: only with `PSG_STEREO_EN`. Per-chip Game Gear pan register.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Condition: `nWE`=0 and at least one `nCE` bit is 0.
  - On that edge: capture `d`, capture the chip mask (~`nCE`) and `stereoSel`, clear the counter, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Counter increments every cycle.
  - At counter == WAIT_CYCLES-1: commit the captured byte to every masked chip, go to DONE.
  - Changes on the bus, `nCE` or `nWE` while in WAIT are ignored.
- DONE: return to IDLE only once all `nCE` bits are 1 and `nWE` is 1. A strobe held low after the commit never causes a second commit.
- `ready` = 0 only in WAIT.
- Commit rules, applied per selected chip. The latched register r is 3 bits:
  - Latch byte (d[7]=1):
    - r <= d[6:4].
    - r=0/2/4: freq[ch r/2][3:0] <= d[3:0].
    - r=1/3/5/7: att[ch (r-1)/2] <= d[3:0].
    - r=6: noiseFeedback <= d[2], noiseFeed <= d[1:0], pulse noiseReset.
  - Data byte (d[7]=0), r unchanged:
    - Tone r: freq[9:4] <= d[5:0], low nibble kept.
    - Attenuation r: att <= d[3:0].
    - r=6: same as the latch-byte rule for r=6, including the noiseReset pulse.
  - Each chip keeps its own r. A broadcast data byte uses each chip's own r.
- Stereo write (stereoSel=1): stereo[k] <= d for the selected chips. Latch state and PSG registers are untouched.
- Reset values:
  - freq 0, att 4'hF (silent).
  - noiseFeedback 0, noiseFeed 0, noiseReset 0.
  - r 0, stereo 8'hFF.
  - State IDLE, so `ready`=1.

## Timing
- Strobe sampled at edge E0. `ready` is low from after E0 until after edge E0+WAIT_CYCLES, i.e. exactly WAIT_CYCLES cycles.
- Register outputs and `ready`=1 update on the same edge, E0+WAIT_CYCLES.
- `noiseReset` is high for exactly the one cycle after the commit edge.
- nReset=0 in any state: next edge forces all reset values and IDLE. A write in progress is discarded and no partial commit occurs.
- nReset=0 coinciding with a strobe: reset wins, and the strobe is not captured.
- A new strobe is accepted no earlier than one cycle after the IDLE return, so minimum write spacing is WAIT_CYCLES+2 cycles.
- Counter width is 8 bits. It never wraps, because commit precedes overflow.

## Configuration
- `PSG_STEREO_EN` defined: `stereoSel` input and `stereo` output exist, and the stereo write path is active.
- Not defined: both ports and the stereo register are absent. Every write goes to the PSG registers.

## Test plan
- Reset, CHIPS=1, WAIT_CYCLES=32: write 0x8A then 0x3F with nCE[0]=0 → freq ch0=0x3FA. `ready` low 32 cycles for each write.
- Latch 0x9F → att ch0=0xF, then data 0x05 → att ch0=0x5, freq unchanged.
- Latch 0xE5 → noiseFeedback=1, noiseFeed=01, noiseReset high exactly 1 cycle. Then data 0x02 → noiseFeedback=0, noiseFeed=10, second pulse.
- CHIPS=2, broadcast: both nCE low, write 0xD0 → att ch2=0 on both chips. Then nCE=2'b10, data 0x07 → only chip0 ch2 att=7.
- Assert nReset at cycle 10 of WAIT → no commit, all reset values, `ready`=1 next cycle. Holding nCE/nWE low after a commit yields no second commit.
- With PSG_STEREO_EN: stereoSel=1, write 0x5A → stereo=0x5A. r and freq are unchanged, and a following data byte still targets the prior latched register.
